pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Pipeline control unit (CU) for the 5-stage RV32I core. Sits beside IDU and takes its decode results.
//  Keeps a per-register write-back scoreboard and stalls PC and IF/ID on RAW hazards.
//  Sequences the branch/jump redirect from EXU: redirects the PC and flushes IF/ID and ID/EX.
//  This block is the sole source of the hold/flush controls for PC, IF/ID and ID/EX.
// PARAMETERS
//  CNT_W         2   width of each per-register pending-write counter (max in-flight writers = 2^CNT_W-1)
//  FLUSH_CYCLES  2   cycles flush stays asserted after a redirect (>=1)
// PORTS
//  clk                  in   1   core clock; all state updates on posedge
//  rst                  in   1   synchronous, active-high reset
//  id2cu_valid_i        in   1   ID stage holds a real instruction
//  id2cu_rs1_addr_i     in   5   rs1 read by instruction in ID (0 = none)
//  id2cu_rs2_addr_i     in   5   rs2 read by instruction in ID (0 = none)
//  id2cu_rd_addr_i      in   5   rd of instruction in ID
//  id2cu_wb_en_i        in   1   instruction in ID writes rd
//  ex2cu_jump_en_i      in   1   EX resolved a taken branch/jump this cycle
//  ex2cu_jump_addr_i    in   32  redirect target
//  wb2cu_wb_en_i        in   1   WB writes the register file this cycle
//  wb2cu_rd_addr_i      in   5   register written by WB
//  cu2pc_hold_o         out  1   freeze PC
//  cu2ifid_hold_o       out  1   freeze IF/ID
//  cu2ifid_flush_o      out  1   load NOP into IF/ID
//  cu2idex_flush_o      out  1   load bubble into ID/EX
//  cu2pc_jump_en_o      out  1   PC takes cu2pc_jump_addr_o
//  cu2pc_jump_addr_o    out  32  redirect target
//  cu2id_issue_o        out  1   instruction in ID advances to ID/EX this cycle
// BEHAVIOUR
//  Reset: all pending counters = 0; FSM = IDLE; flush counter = 0. All outputs are 0 while rst is high.
//  Redirect path is combinational: jump_en_o = ex2cu_jump_en_i; jump_addr_o = ex2cu_jump_addr_i; zero latency.
//  Flush FSM has states IDLE and FLUSH.
//   IDLE --jump_en--> FLUSH, fcnt <= FLUSH_CYCLES-1. Flush outputs are already asserted in the jump cycle.
//   FLUSH: fcnt decrements each cycle; goes to IDLE when fcnt==0 and no new jump.
//   A jump in FLUSH reloads fcnt and the newest target wins.
//   flush_active = jump_en | (state==FLUSH). It drives cu2ifid_flush_o = cu2idex_flush_o = 1.
//   Total flush length per redirect = FLUSH_CYCLES cycles, counted from and including the jump cycle.
//  Hazard detection (combinational):
//   raw  = (rs1!=0 & cnt[rs1]!=0) | (rs2!=0 & cnt[rs2]!=0)
//   sat  = wb_en & rd!=0 & cnt[rd]==all-ones
//   stall = id2cu_valid_i & (raw | sat) & ~flush_active
//  When stall=1: pc_hold = ifid_hold = 1 and idex_flush = 1 (bubble).
//  Flush has priority over stall: during flush, hold=0.
//  issue_o = id2cu_valid_i & ~stall & ~flush_active.
//  Scoreboard update, per register r (r=1..31), each posedge:
//   inc = issue_o & id2cu_wb_en_i & rd==r; dec = wb2cu_wb_en_i & wb_rd==r
//   inc&~dec: +1; dec&~inc: -1 (saturates at 0, never wraps); inc&dec: unchanged.
//  x0 is never tracked; cnt[0] is constant 0.
//  WB to a register in the same cycle ID reads it: WB's decrement is not visible until next cycle, so ID stalls one more cycle.
//  rst mid-operation clears all counters and FSM in one cycle. In-flight writebacks after reset are ignored by saturation at 0.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: adds outputs cu_stall_cnt_o[31:0] and cu_flush_cnt_o[31:0].
//   cu_stall_cnt_o increments each cycle stall=1; cu_flush_cnt_o increments on each jump_en.
//   Both counters wrap at 2^32, are cleared by rst, and read combinationally from the registers.
//  Undefined: those ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1 Reset: rst=1 for 2 cycles with random inputs -> all outputs 0; after release, RAW check on x5 sees no stall.
//  2 RAW: issue wb to x5; next cycle ID reads rs1=x5 -> stall with hold=1 and idex_flush=1 until WB x5 arrives. Issue resumes the cycle after WB.
//  3 Redirect: jump_en=1, addr=0x80 -> jump_en_o=1 and addr_o=0x80 same cycle; flush=1 for exactly 2 cycles; issue_o=0 during them.
//  4 Back-to-back jumps 0x40 then 0x100 one cycle apart -> addr_o follows each; flush lasts 2 cycles after the second jump.
//  5 Saturation: three issues writing x7 with no WB -> 4th writer of x7 stalls. One WB of x7 -> issue resumes. Same-cycle issue+WB of x7 leaves count unchanged.
//  6 x0 and priority: rd=x0 writes never stall later readers of x0. Stall and jump in the same cycle -> hold=0 and flush=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl - pipeline control unit for the 5-stage RV32I core.
//
// Owns every hold/flush control for PC, IF/ID and ID/EX:
//   * per-register pending-write scoreboard -> RAW / saturation stall
//   * EX branch/jump redirect -> PC redirect plus multi-cycle flush of IF/ID, ID/EX
//
// Parameters
//   CNT_W         width of each pending-write counter (max in-flight writers 2^CNT_W-1)
//   FLUSH_CYCLES  flush length per redirect, including the jump cycle (>=1)
//
// Ports
//   clk, rst                       core clock, synchronous active-high reset
//   id2cu_*                        decode info of the instruction sitting in ID
//   ex2cu_jump_en_i/_addr_i        taken branch/jump resolved in EX
//   wb2cu_wb_en_i/_rd_addr_i       register file write in WB
//   cu2pc_hold_o, cu2ifid_hold_o   freeze PC / IF/ID (RAW stall)
//   cu2ifid_flush_o                NOP into IF/ID (redirect)
//   cu2idex_flush_o                bubble into ID/EX (redirect or stall)
//   cu2pc_jump_en_o/_addr_o        PC redirect, zero latency from EX
//   cu2id_issue_o                  instruction in ID advances this cycle
//
// Build option
//   HAZARD_PERF_CNT_EN  adds cu_stall_cnt_o / cu_flush_cnt_o performance counters.
//
// All outputs are forced low while rst is high.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no redirect in progress; flush only if EX jumps this cycle
// FLUSH  | trailing flush cycles after a redirect, fcnt = cycles left

module pipe_hazard_ctrl #(
  parameter int CNT_W        = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id2cu_valid_i,
  input  logic [4:0]  id2cu_rs1_addr_i,
  input  logic [4:0]  id2cu_rs2_addr_i,
  input  logic [4:0]  id2cu_rd_addr_i,
  input  logic        id2cu_wb_en_i,
  input  logic        ex2cu_jump_en_i,
  input  logic [31:0] ex2cu_jump_addr_i,
  input  logic        wb2cu_wb_en_i,
  input  logic [4:0]  wb2cu_rd_addr_i,
  output logic        cu2pc_hold_o,
  output logic        cu2ifid_hold_o,
  output logic        cu2ifid_flush_o,
  output logic        cu2idex_flush_o,
  output logic        cu2pc_jump_en_o,
  output logic [31:0] cu2pc_jump_addr_o,
  output logic        cu2id_issue_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] cu_stall_cnt_o,
  output logic [31:0] cu_flush_cnt_o
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam int FC_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {
    S_IDLE,
    S_FLUSH
  } state_t;

  state_t          state_q, state_d;
  logic [FC_W-1:0] fcnt_q, fcnt_d;

  logic [CNT_W-1:0] cnt_q [32];

  logic flush_active;
  logic raw;
  logic sat;
  logic stall;
  logic issue;

  // ---------------------------------------------------------------
  // Flush sequencer
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // fcnt counts the FLUSH cycles still owed, including the current one,
  // so the jump cycle plus (FLUSH_CYCLES-1) FLUSH cycles gives the full length.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      S_IDLE: begin
        if (ex2cu_jump_en_i) begin
          fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
          state_d = (FLUSH_CYCLES > 1) ? S_FLUSH : S_IDLE;
        end
      end
      S_FLUSH: begin
        if (ex2cu_jump_en_i) begin
          fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
          state_d = (FLUSH_CYCLES > 1) ? S_FLUSH : S_IDLE;
        end else if (fcnt_q <= FC_W'(1)) begin
          fcnt_d  = '0;
          state_d = S_IDLE;
        end else begin
          fcnt_d  = fcnt_q - FC_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        fcnt_d  = '0;
      end
    endcase
  end

  assign flush_active = ex2cu_jump_en_i | (state_q == S_FLUSH);

  // ---------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------
  always_comb begin
    raw = ((id2cu_rs1_addr_i != 5'd0) && (cnt_q[id2cu_rs1_addr_i] != '0)) ||
          ((id2cu_rs2_addr_i != 5'd0) && (cnt_q[id2cu_rs2_addr_i] != '0));
    // Another writer would overflow the counter for rd.
    sat = id2cu_wb_en_i && (id2cu_rd_addr_i != 5'd0) &&
          (cnt_q[id2cu_rd_addr_i] == CNT_MAX);
  end

  assign stall = id2cu_valid_i & (raw | sat) & ~flush_active;
  assign issue = id2cu_valid_i & ~stall & ~flush_active;

  // ---------------------------------------------------------------
  // Scoreboard: x0 is held at zero so it never produces a hazard.
  // A WB decrement only becomes visible the cycle after, so a reader
  // in ID during the WB cycle still stalls once more.
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int r = 0; r < 32; r++) begin
      if (rst || (r == 0)) begin
        cnt_q[r] <= '0;
      end else begin
        logic inc;
        logic dec;
        inc = issue && id2cu_wb_en_i && (id2cu_rd_addr_i == 5'(r));
        dec = wb2cu_wb_en_i && (wb2cu_rd_addr_i == 5'(r));
        if (inc && !dec && (cnt_q[r] != CNT_MAX)) begin
          cnt_q[r] <= cnt_q[r] + CNT_W'(1);
        end else if (dec && !inc && (cnt_q[r] != '0)) begin
          cnt_q[r] <= cnt_q[r] - CNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------
  assign cu2pc_hold_o      = ~rst & stall;
  assign cu2ifid_hold_o    = ~rst & stall;
  assign cu2ifid_flush_o   = ~rst & flush_active;
  assign cu2idex_flush_o   = ~rst & (flush_active | stall);
  assign cu2pc_jump_en_o   = ~rst & ex2cu_jump_en_i;
  assign cu2pc_jump_addr_o = rst ? 32'd0 : ex2cu_jump_addr_i;
  assign cu2id_issue_o     = ~rst & issue;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (ex2cu_jump_en_i) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign cu_stall_cnt_o = rst ? 32'd0 : stall_cnt_q;
  assign cu_flush_cnt_o = rst ? 32'd0 : flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a table of per-cycle vectors with
// hand-computed expected outputs, plus hand-written reset sequences.
// Expected output vector order: {pc_hold, ifid_hold, ifid_flush, idex_flush, jump_en, issue}.

module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id2cu_valid_i;
  logic [4:0]  id2cu_rs1_addr_i;
  logic [4:0]  id2cu_rs2_addr_i;
  logic [4:0]  id2cu_rd_addr_i;
  logic        id2cu_wb_en_i;
  logic        ex2cu_jump_en_i;
  logic [31:0] ex2cu_jump_addr_i;
  logic        wb2cu_wb_en_i;
  logic [4:0]  wb2cu_rd_addr_i;
  logic        cu2pc_hold_o;
  logic        cu2ifid_hold_o;
  logic        cu2ifid_flush_o;
  logic        cu2idex_flush_o;
  logic        cu2pc_jump_en_o;
  logic [31:0] cu2pc_jump_addr_o;
  logic        cu2id_issue_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] cu_stall_cnt_o;
  logic [31:0] cu_flush_cnt_o;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(2), .FLUSH_CYCLES(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .id2cu_valid_i     (id2cu_valid_i),
    .id2cu_rs1_addr_i  (id2cu_rs1_addr_i),
    .id2cu_rs2_addr_i  (id2cu_rs2_addr_i),
    .id2cu_rd_addr_i   (id2cu_rd_addr_i),
    .id2cu_wb_en_i     (id2cu_wb_en_i),
    .ex2cu_jump_en_i   (ex2cu_jump_en_i),
    .ex2cu_jump_addr_i (ex2cu_jump_addr_i),
    .wb2cu_wb_en_i     (wb2cu_wb_en_i),
    .wb2cu_rd_addr_i   (wb2cu_rd_addr_i),
    .cu2pc_hold_o      (cu2pc_hold_o),
    .cu2ifid_hold_o    (cu2ifid_hold_o),
    .cu2ifid_flush_o   (cu2ifid_flush_o),
    .cu2idex_flush_o   (cu2idex_flush_o),
    .cu2pc_jump_en_o   (cu2pc_jump_en_o),
    .cu2pc_jump_addr_o (cu2pc_jump_addr_o),
    .cu2id_issue_o     (cu2id_issue_o)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .cu_stall_cnt_o    (cu_stall_cnt_o),
    .cu_flush_cnt_o    (cu_flush_cnt_o)
`endif
  );

  typedef struct {
    logic        rst;
    logic        vld;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wen;
    logic        jmp;
    logic [31:0] ja;
    logic        wbv;
    logic [4:0]  wbrd;
    logic [5:0]  exp;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t tbl[$];

  localparam logic [5:0] E_NONE  = 6'b000000;
  localparam logic [5:0] E_ISSUE = 6'b000001;
  localparam logic [5:0] E_STALL = 6'b110100;
  localparam logic [5:0] E_JUMP  = 6'b001110;
  localparam logic [5:0] E_FLUSH = 6'b001100;

  function automatic vec_t mk(logic r, logic vld, logic [4:0] rs1, logic [4:0] rs2,
                              logic [4:0] rd, logic wen, logic jmp, logic [31:0] ja,
                              logic wbv, logic [4:0] wbrd, logic [5:0] exp);
    vec_t v;
    v.rst = r; v.vld = vld; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.wen = wen;
    v.jmp = jmp; v.ja = ja; v.wbv = wbv; v.wbrd = wbrd; v.exp = exp;
    v.exp_addr = r ? 32'd0 : ja;
    return v;
  endfunction

  // Drive one cycle's inputs, check combinational outputs, then advance.
  task automatic apply(input vec_t v, input string name);
    logic [5:0] got;
    rst               = v.rst;
    id2cu_valid_i     = v.vld;
    id2cu_rs1_addr_i  = v.rs1;
    id2cu_rs2_addr_i  = v.rs2;
    id2cu_rd_addr_i   = v.rd;
    id2cu_wb_en_i     = v.wen;
    ex2cu_jump_en_i   = v.jmp;
    ex2cu_jump_addr_i = v.ja;
    wb2cu_wb_en_i     = v.wbv;
    wb2cu_rd_addr_i   = v.wbrd;
    #1;
    got = {cu2pc_hold_o, cu2ifid_hold_o, cu2ifid_flush_o, cu2idex_flush_o,
           cu2pc_jump_en_o, cu2id_issue_o};
    n_chk++;
    if (got !== v.exp || cu2pc_jump_addr_o !== v.exp_addr) begin
      n_fail++;
      $display("FAIL %s: got outs=%b addr=%h, expected outs=%b addr=%h",
               name, got, cu2pc_jump_addr_o, v.exp, v.exp_addr);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t rv;

    // 1: reset with random inputs -> every output low
    rst = 1'b1;
    id2cu_valid_i = 0; id2cu_rs1_addr_i = 0; id2cu_rs2_addr_i = 0; id2cu_rd_addr_i = 0;
    id2cu_wb_en_i = 0; ex2cu_jump_en_i = 0; ex2cu_jump_addr_i = 0;
    wb2cu_wb_en_i = 0; wb2cu_rd_addr_i = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      rv = mk(1'b1, 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
              1'b1, $urandom, 1'($urandom), 5'($urandom), E_NONE);
      apply(rv, $sformatf("reset%0d", i));
    end

    // fields: rst vld rs1 rs2 rd wen jmp ja wbv wbrd exp
    // after reset: no stall on x5
    tbl.push_back(mk(0, 1, 5, 0, 0, 0, 0, 32'h0,   0, 0, E_ISSUE));
    // 2: RAW on x5
    tbl.push_back(mk(0, 1, 0, 0, 5, 1, 0, 32'h0,   0, 0, E_ISSUE));
    tbl.push_back(mk(0, 1, 5, 0, 6, 1, 0, 32'h0,   0, 0, E_STALL));
    tbl.push_back(mk(0, 1, 5, 0, 6, 1, 0, 32'h0,   0, 0, E_STALL));
    tbl.push_back(mk(0, 1, 5, 0, 6, 1, 0, 32'h0,   1, 5, E_STALL));
    tbl.push_back(mk(0, 1, 5, 0, 6, 1, 0, 32'h0,   0, 0, E_ISSUE));
    // 3: redirect 0x80, flush 2 cycles; retire x6 meanwhile
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 32'h80,  0, 0, E_JUMP));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 32'h0,   1, 6, E_FLUSH));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 32'h0,   0, 0, E_ISSUE));
    // 4: back-to-back jumps
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 32'h40,  0, 0, E_JUMP));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 32'h100, 0, 0, E_JUMP));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 32'h0,   0, 0, E_FLUSH));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 32'h0,   0, 0, E_ISSUE));
    // 5: saturation on x7
    tbl.push_back(mk(0, 1, 0, 0, 7, 1, 0, 32'h0,   0, 0, E_ISSUE));
    tbl.push_back(mk(0, 1, 0, 0, 7, 1, 0, 32'h0,   0, 0, E_ISSUE));
    tbl.push_back(mk(0, 1, 0, 0, 7, 1, 0, 32'h0,   0, 0, E_ISSUE));
    tbl.push_back(mk(0, 1, 0, 0, 7, 1, 0, 32'h0,   0, 0, E_STALL));
    tbl.push_back(mk(0, 1, 0, 0, 7, 1, 0, 32'h0,   1, 7, E_STALL));  // count 3 -> 2
    tbl.push_back(mk(0, 1, 0, 0, 7, 1, 0, 32'h0,   1, 7, E_ISSUE));  // issue+WB: stays 2
    tbl.push_back(mk(0, 1, 0, 0, 7, 1, 0, 32'h0,   0, 0, E_ISSUE));  // -> 3
    tbl.push_back(mk(0, 1, 0, 0, 7, 1, 0, 32'h0,   0, 0, E_STALL));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,   1, 7, E_NONE));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,   1, 7, E_NONE));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,   1, 7, E_NONE));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,   1, 7, E_NONE));  // extra WB, no wrap
    tbl.push_back(mk(0, 1, 7, 0, 0, 0, 0, 32'h0,   0, 0, E_ISSUE));
    // 6: x0 never tracked; jump beats stall
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 32'h0,   0, 0, E_ISSUE));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 32'h0,   0, 0, E_ISSUE));
    tbl.push_back(mk(0, 1, 0, 0, 9, 1, 0, 32'h0,   0, 0, E_ISSUE));
    tbl.push_back(mk(0, 1, 0, 9, 0, 0, 1, 32'h200, 0, 0, E_JUMP));
    tbl.push_back(mk(0, 1, 0, 9, 0, 0, 0, 32'h0,   0, 0, E_FLUSH));
    tbl.push_back(mk(0, 1, 0, 9, 0, 0, 0, 32'h0,   0, 0, E_STALL));
    tbl.push_back(mk(0, 1, 0, 9, 0, 0, 0, 32'h0,   1, 9, E_STALL));
    tbl.push_back(mk(0, 1, 0, 9, 0, 0, 0, 32'h0,   0, 0, E_ISSUE));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset mid-operation: pending x11 writer and an active flush are both cleared.
    apply(mk(0, 1, 0, 0, 11, 1, 0, 32'h0,   0, 0,  E_ISSUE), "mid_issue_x11");
    apply(mk(0, 1, 0, 0, 0,  0, 1, 32'h300, 0, 0,  E_JUMP),  "mid_jump");
    apply(mk(1, 1, 11, 0, 0, 0, 1, 32'h304, 1, 3,  E_NONE),  "mid_reset");
    apply(mk(0, 1, 11, 0, 0, 0, 0, 32'h0,   0, 0,  E_ISSUE), "post_reset_x11");
    apply(mk(0, 1, 0, 0, 0,  0, 0, 32'h0,   1, 11, E_ISSUE), "stale_wb_x11");
    apply(mk(0, 1, 11, 11, 0, 0, 0, 32'h0,  0, 0,  E_ISSUE), "x11_no_wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
